// File: rtl/mc_control_fsm_if.sv
// Control-unit bundle: instruction/memory status in, datapath strobes and debug status out.
// The master side is the controller; the slave side is the datapath/memory that consumes the strobes.
interface mc_control_fsm_if;
    logic [5:0] Opcode;
    logic       mem_ready;

    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       PCWrite;
    logic       Branch;
    logic [1:0] ALUSrcB;
    logic [1:0] ALU_Op;
    logic [1:0] PCSrc;

    logic [3:0] state_o;
    logic       mem_err;
    logic       illegal_op;

    modport master (
        input  Opcode, mem_ready,
        output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, PCWrite, Branch, ALUSrcB, ALU_Op, PCSrc,
               state_o, mem_err, illegal_op
    );

    modport slave (
        output Opcode, mem_ready,
        input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, PCWrite, Branch, ALUSrcB, ALU_Op, PCSrc,
               state_o, mem_err, illegal_op
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-style control FSM: strobes decode combinationally from the current state.
// Memory states stall on mem_ready=0; a bounded stall (MEM_TIMEOUT) or a bad opcode parks the FSM in ERROR.
module mc_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    mc_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_ERROR  = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam bit         TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q;
    logic [5:0] opc_q;
    logic       mem_err_q;
    logic       ill_q;

    logic       in_wait;
    logic       tmo_hit;
    logic       dec_ill;

    assign in_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                     && !bus.mem_ready;
    assign tmo_hit = TO_EN && in_wait && (wait_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        dec_ill = 1'b0;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_ERROR;
                        dec_ill = 1'b1;
                    end
                endcase
            end
            // Uses the opcode captured in DECODE; the IR input may already be changing.
            S_MEMADR: begin
                if (opc_q == OP_LW)      state_d = S_MEMRD;
                else if (opc_q == OP_SW) state_d = S_MEMWR;
                else                     state_d = S_ERROR;
            end
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_ERROR;
        endcase
        // A completing access (mem_ready=1) never reaches here since tmo_hit needs a wait cycle.
        if (tmo_hit) state_d = S_ERROR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= 8'd0;
            opc_q     <= 6'd0;
            mem_err_q <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_q <= 8'd0;
            end else if (in_wait && (wait_q != 8'hFF)) begin
                wait_q <= wait_q + 8'd1;
            end
            if (state_q == S_DECODE) opc_q <= bus.Opcode;
            if (tmo_hit) mem_err_q <= 1'b1;
            if (dec_ill) ill_q <= 1'b1;
        end
    end

    logic       iord, mem_read, mem_write, ir_write, reg_dst, memto_reg;
    logic       reg_write, alu_src_a, pc_write, branch;
    logic [1:0] alu_src_b, alu_op, pc_src;

    // Gating on rst_n makes every strobe drop the instant reset asserts, even mid-access.
    always_comb begin
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_dst   = 1'b0;
        memto_reg = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 1'b0;
        pc_write  = 1'b0;
        branch    = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        pc_src    = 2'b00;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = bus.mem_ready;
                    pc_write  = bus.mem_ready;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write = 1'b1;
                    memto_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    branch    = 1'b1;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDIWB: reg_write = 1'b1;
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.IorD       = iord;
    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.RegDst     = reg_dst;
    assign bus.MemtoReg   = memto_reg;
    assign bus.RegWrite   = reg_write;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.PCWrite    = pc_write;
    assign bus.Branch     = branch;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALU_Op     = alu_op;
    assign bus.PCSrc      = pc_src;
    assign bus.state_o    = state_q;
    assign bus.mem_err    = mem_err_q;
    assign bus.illegal_op = ill_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-level model emits expected per-cycle records; a monitor checks them.
module tb_mc_control_fsm;

    localparam int T = 4;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RTY  = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] sb;
        logic        me;
        logic        io;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mc_control_fsm_if bus();

    mc_control_fsm #(.MEM_TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   m_mem_err = 1'b0;
    bit   m_ill     = 1'b0;

    // Bit order: IorD MemRead MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA PCWrite Branch ALUSrcB ALU_Op PCSrc
    function automatic logic [15:0] exp_sb(int st, bit rdy);
        logic [15:0] v;
        v = '0;
        case (st)
            0:  begin v[14] = 1'b1; v[12] = rdy; v[7] = rdy; v[5:4] = 2'b01; end
            1:  v[5:4] = 2'b11;
            2:  begin v[8] = 1'b1; v[5:4] = 2'b10; end
            3:  begin v[15] = 1'b1; v[14] = 1'b1; end
            4:  begin v[9] = 1'b1; v[10] = 1'b1; end
            5:  begin v[15] = 1'b1; v[13] = 1'b1; end
            6:  begin v[8] = 1'b1; v[3:2] = 2'b10; end
            7:  begin v[9] = 1'b1; v[11] = 1'b1; end
            8:  begin v[8] = 1'b1; v[3:2] = 2'b01; v[1:0] = 2'b01; v[6] = 1'b1; end
            9:  begin v[8] = 1'b1; v[5:4] = 2'b10; end
            10: v[9] = 1'b1;
            11: begin v[1:0] = 2'b10; v[7] = 1'b1; end
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    task automatic cyc(int st, bit rdy, logic [5:0] opc);
        exp_t e;
        bus.mem_ready = rdy;
        bus.Opcode    = opc;
        e.st = 4'(st);
        e.sb = exp_sb(st, rdy);
        e.me = m_mem_err;
        e.io = m_ill;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_t e;
        e = '0;
        rst_n = 1'b0;
        m_mem_err = 1'b0;
        m_ill     = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) begin
            q.push_back(e);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic err_tail();
        repeat (3) cyc(12, 1'($urandom), rnd6());
        do_reset();
    endtask

    // One memory access of 'waits' not-ready cycles; aborts into ERROR after T consecutive waits.
    task automatic access(int st, int waits, output bit to);
        to = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                cyc(st, 1'b1, rnd6());
            end else begin
                cyc(st, 1'b0, rnd6());
                if (i == T - 1) begin
                    to = 1'b1;
                    m_mem_err = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic instr(logic [5:0] opc, int wf, int wm);
        bit to;
        access(0, wf, to);
        if (to) begin err_tail(); return; end
        cyc(1, 1'($urandom), opc);
        case (opc)
            LW, SW: begin
                // Present the other memory opcode so only the captured one can steer MEMADR.
                cyc(2, 1'($urandom), (opc == LW) ? SW : LW);
                access((opc == LW) ? 3 : 5, wm, to);
                if (to) begin err_tail(); return; end
                if (opc == LW) cyc(4, 1'($urandom), rnd6());
            end
            RTY:  begin cyc(6, 1'($urandom), rnd6()); cyc(7, 1'($urandom), rnd6()); end
            BEQ:  cyc(8, 1'($urandom), rnd6());
            ADDI: begin cyc(9, 1'($urandom), rnd6()); cyc(10, 1'($urandom), rnd6()); end
            JMP:  cyc(11, 1'($urandom), rnd6());
            default: begin
                m_ill = 1'b1;
                err_tail();
            end
        endcase
    endtask

    initial begin : monitor
        exp_t e;
        logic [15:0] a_sb;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                a_sb = {bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
                        bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.PCWrite, bus.Branch,
                        bus.ALUSrcB, bus.ALU_Op, bus.PCSrc};
                total++;
                if (bus.state_o !== e.st || a_sb !== e.sb ||
                    bus.mem_err !== e.me || bus.illegal_op !== e.io) begin
                    bad++;
                    $display("FAIL cycle_check #%0d t=%0t: got st=%0d sb=%h mem_err=%b ill=%b, want st=%0d sb=%h mem_err=%b ill=%b",
                             total, $time, bus.state_o, a_sb, bus.mem_err, bus.illegal_op,
                             e.st, e.sb, e.me, e.io);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [5:0] legal [6];
        logic [5:0] opc;
        int wf, wm;
        bit to;
        legal[0] = LW; legal[1] = SW; legal[2] = RTY;
        legal[3] = BEQ; legal[4] = ADDI; legal[5] = JMP;
        rst_n = 1'b0;
        bus.Opcode = 6'd0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        instr(LW, 0, 0);
        instr(RTY, 0, 0);
        instr(LW, 3, 1);       // fetch stalls 3 then completes on the last allowed cycle
        instr(SW, 0, 3);       // store completes exactly when the timeout would fire
        instr(LW, 0, 9);       // read stuck -> timeout in MEMRD
        instr(6'b111111, 0, 0);
        instr(BEQ, 1, 0);
        instr(JMP, 0, 0);
        instr(ADDI, 2, 0);
        instr(SW, 5, 0);       // fetch timeout

        // Reset asserted in the middle of a stalled store.
        access(0, 0, to);
        cyc(1, 1'b1, SW);
        cyc(2, 1'b1, LW);
        cyc(5, 1'b0, rnd6());
        cyc(5, 1'b0, rnd6());
        do_reset();
        instr(SW, 0, 0);

        for (int n = 0; n < 200; n++) begin
            opc = legal[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0) opc = rnd6();
            wf = ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 3));
            wm = ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 3));
            instr(opc, wf, wm);
        end

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected records left unchecked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have one parameter: MEM_TIMEOUT, default 15, the number of consecutive not-ready wait cycles before a memory error; legal range 0..255, where 0 disables the timeout.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 Opcode  in  6  instruction opcode from the IR; sampled only in DECODE.
REQ-005 mem_ready  in  1  memory completes the current access this cycle.
REQ-006 Outputs, 1 bit each: IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite, Branch; these are datapath strobes and selects.
REQ-007 Outputs, 2 bits each: ALUSrcB, ALU_Op (to ALUControl), PCSrc.
REQ-008 state_o  out  4  current state encoding, for debug.
REQ-009 mem_err  out  1  sticky memory-timeout flag; illegal_op  out  1  sticky illegal-opcode flag.

Function
REQ-010 State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ERROR=12; codes 13-15 SHALL go to ERROR on the next edge.
REQ-011 Outputs SHALL be combinational from the state, with IRWrite and PCWrite in FETCH additionally qualified by mem_ready; every output not listed for a state SHALL be 0.
REQ-012 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_Op=00, PCSrc=00; IRWrite=PCWrite=mem_ready; go to DECODE when mem_ready=1, otherwise stay.
REQ-013 DECODE: ALUSrcA=0, ALUSrcB=11, ALU_Op=00; next state by Opcode: 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP; any other value->ERROR with illegal_op set.
REQ-014 MEMADR: ALUSrcA=1, ALUSrcB=10, ALU_Op=00; go to MEMRD if the latched opcode is lw (100011), to MEMWR if it is sw.
REQ-015 The opcode seen in DECODE SHALL be latched internally on leaving DECODE; MEMADR SHALL use the latched value, not the live Opcode input.
REQ-016 MEMRD: MemRead=1, IorD=1; go to MEMWB when mem_ready=1, otherwise stay.
REQ-017 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; then go to FETCH.
REQ-018 MEMWR: MemWrite=1, IorD=1; go to FETCH when mem_ready=1, otherwise stay.
REQ-019 EXEC: ALUSrcA=1, ALUSrcB=00, ALU_Op=10; then go to ALUWB.
REQ-020 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; then go to FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_Op=01, PCSrc=01, Branch=1; then go to FETCH.
REQ-022 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALU_Op=00; then go to ADDIWB.
REQ-023 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; then go to FETCH.
REQ-024 JUMP: PCSrc=10, PCWrite=1; then go to FETCH.
REQ-025 Wait counter (8 bit): increments on each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0; clears on every state change.
REQ-026 Timeout: if MEM_TIMEOUT!=0, the counter equals MEM_TIMEOUT-1 and mem_ready=0, the next state SHALL be ERROR and mem_err SHALL be set.
REQ-027 If mem_ready=1 in the same cycle the timeout would fire, the access SHALL complete normally and no error SHALL be raised.
REQ-028 ERROR: all strobes 0, state held, mem_err and illegal_op held, until reset.
REQ-029 Cycle counts with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; each mem_ready=0 cycle adds one.

Reset
REQ-030 While rst_n=0: state=FETCH, wait counter=0, latched opcode=0, mem_err=illegal_op=0, and all strobes (including MemRead and the FETCH strobes) SHALL be forced to 0 asynchronously.
REQ-031 A reset asserted in any state, including mid-access in MEMWR, SHALL drop MemWrite in the same cycle; after rst_n rises, operation SHALL restart at FETCH on the first clock edge.

Verification
REQ-032 lw, mem_ready=1 throughout -> state_o 0,1,2,3,4,0 over 5 cycles; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-033 R-type (000000) -> state_o 0,1,6,7; ALU_Op=10 in EXEC; RegWrite=1 with RegDst=1 in ALUWB.
REQ-034 FETCH with mem_ready held 0 for 3 cycles, then 1 -> state stays 0 for 4 cycles; IRWrite and PCWrite pulse only in the 4th cycle.
REQ-035 MEM_TIMEOUT=4, mem_ready stuck 0 in MEMRD -> ERROR after 4 wait cycles; mem_err=1 and all strobes 0 until rst_n pulses low.
REQ-036 Opcode=111111 in DECODE -> ERROR (12) next cycle with illegal_op=1.
REQ-037 rst_n driven low mid-MEMWR -> MemWrite=0 immediately; after release, state_o=0 with mem_err=0 and illegal_op=0.
